// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports and the memory-side bus of dmem_arbiter.
//   Requester n (0 = CPU MEM stage, 1 = loader/debug):
//     reqn/rwn/sizen/addrn/wdatan  requester -> arbiter
//     ackn/errn/rdatan             arbiter -> requester (valid with ackn)
//   Memory side:
//     mem_a/mem_di/mem_size/mem_rw/mem_e  arbiter -> memory
//     mem_do                              memory -> arbiter (combinational)
// modport slave is the arbiter's view; modport master is the environment's.
interface dmem_arbiter_if;
  logic        req0;
  logic        rw0;
  logic [1:0]  size0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic        err0;
  logic [31:0] rdata0;

  logic        req1;
  logic        rw1;
  logic [1:0]  size1;
  logic [7:0]  addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic        err1;
  logic [31:0] rdata1;

  logic [7:0]  mem_a;
  logic [31:0] mem_di;
  logic [1:0]  mem_size;
  logic        mem_rw;
  logic        mem_e;
  logic [31:0] mem_do;

  modport slave (
    input  req0, rw0, size0, addr0, wdata0,
    output ack0, err0, rdata0,
    input  req1, rw1, size1, addr1, wdata1,
    output ack1, err1, rdata1,
    output mem_a, mem_di, mem_size, mem_rw, mem_e,
    input  mem_do
  );

  modport master (
    output req0, rw0, size0, addr0, wdata0,
    input  ack0, err0, rdata0,
    output req1, rw1, size1, addr1, wdata1,
    input  ack1, err1, rdata1,
    input  mem_a, mem_di, mem_size, mem_rw, mem_e,
    output mem_do
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter giving two requesters access to a single byte-addressed
// data memory. Each transaction runs IDLE -> ACCESS -> RESP (legal) or
// IDLE -> RESP (illegal, no memory cycle).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    dmem_arbiter_if.slave: requester ports 0/1 and memory bus
//   busy   high whenever the FSM is not in IDLE
// Parameter ALIGN_CHECK: 1 rejects misaligned halfword/word accesses,
// 0 permits them. Accesses running past address 0xFF are always rejected.
module dmem_arbiter #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req;
  logic        grant;
  logic        sel_rw;
  logic [1:0]  sel_size;
  logic [7:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_illegal;

  // Illegal sizes, misalignment (when checked) and running past 0xFF.
  function automatic logic is_illegal(input logic [1:0] size, input logic [7:0] addr);
    logic [8:0] last_byte;
    logic       bad;
    bad       = 1'b0;
    last_byte = {1'b0, addr};
    case (size)
      2'b00: last_byte = {1'b0, addr};
      2'b01: begin
        last_byte = {1'b0, addr} + 9'd1;
        if (ALIGN_CHECK && addr[0]) bad = 1'b1;
      end
      2'b10: begin
        last_byte = {1'b0, addr} + 9'd3;
        if (ALIGN_CHECK && (addr[1:0] != 2'b00)) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (last_byte[8]) bad = 1'b1;
    return bad;
  endfunction

  // Round-robin pick: on contention the port that did not win last time wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    grant   = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant = ~last_grant_q;
    end else if (bus.req1) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
    if (grant) begin
      sel_rw    = bus.rw1;
      sel_size  = bus.size1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end else begin
      sel_rw    = bus.rw0;
      sel_size  = bus.size0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end
    sel_illegal = is_illegal(sel_size, sel_addr);
  end

  // State and request-latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rw_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 8'h00;
      wdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic: latch the winner in IDLE, capture read data in ACCESS.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rw_d         = rw_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          rw_d         = sel_rw;
          size_d       = sel_size;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = sel_illegal;
          // Cleared so illegal accesses and writes return zero data.
          rdata_d      = 32'h0000_0000;
          state_d      = sel_illegal ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!rw_q) begin
          rdata_d = bus.mem_do;
        end else begin
          rdata_d = rdata_q;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; reset clears them at once.
  always_comb begin
    bus.mem_a    = 8'h00;
    bus.mem_di   = 32'h0000_0000;
    bus.mem_size = 2'b00;
    bus.mem_rw   = 1'b0;
    bus.mem_e    = 1'b0;
    bus.ack0     = 1'b0;
    bus.err0     = 1'b0;
    bus.rdata0   = 32'h0000_0000;
    bus.ack1     = 1'b0;
    bus.err1     = 1'b0;
    bus.rdata1   = 32'h0000_0000;
    busy         = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        bus.mem_a    = addr_q;
        bus.mem_di   = wdata_q;
        bus.mem_size = size_q;
        bus.mem_rw   = rw_q;
        bus.mem_e    = rw_q;
      end
      RESP: begin
        if (owner_q) begin
          bus.ack1   = 1'b1;
          bus.err1   = err_q;
          bus.rdata1 = rdata_q;
        end else begin
          bus.ack0   = 1'b1;
          bus.err0   = err_q;
          bus.rdata0 = rdata_q;
        end
      end
      default: begin
        bus.mem_a = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with alignment checking,
// one without, each backed by a small byte-addressed memory model
// initialised to Mem[i] = i ^ 0x5A.
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  logic ram_init;
  logic busy_a, busy_b;
  int   tests_run;
  int   tests_failed;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];

  dmem_arbiter_if bus_a ();
  dmem_arbiter_if bus_b ();

  dmem_arbiter #(.ALIGN_CHECK(1'b1)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a));
  dmem_arbiter #(.ALIGN_CHECK(1'b0)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [1:0] size);
    case (size)
      2'b00:   return {24'h0, b0};
      2'b01:   return {16'h0, b1, b0};
      2'b10:   return {b3, b2, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  assign bus_a.mem_do = mem_read(ram_a[bus_a.mem_a], ram_a[bus_a.mem_a + 8'd1],
                                 ram_a[bus_a.mem_a + 8'd2], ram_a[bus_a.mem_a + 8'd3], bus_a.mem_size);
  assign bus_b.mem_do = mem_read(ram_b[bus_b.mem_a], ram_b[bus_b.mem_a + 8'd1],
                                 ram_b[bus_b.mem_a + 8'd2], ram_b[bus_b.mem_a + 8'd3], bus_b.mem_size);

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) begin
        ram_a[i] <= 8'(i) ^ 8'h5A;
        ram_b[i] <= 8'(i) ^ 8'h5A;
      end
    end else begin
      if (bus_a.mem_e) begin
        ram_a[bus_a.mem_a] <= bus_a.mem_di[7:0];
        if (bus_a.mem_size != 2'b00) ram_a[bus_a.mem_a + 8'd1] <= bus_a.mem_di[15:8];
        if (bus_a.mem_size == 2'b10) begin
          ram_a[bus_a.mem_a + 8'd2] <= bus_a.mem_di[23:16];
          ram_a[bus_a.mem_a + 8'd3] <= bus_a.mem_di[31:24];
        end
      end
      if (bus_b.mem_e) begin
        ram_b[bus_b.mem_a] <= bus_b.mem_di[7:0];
        if (bus_b.mem_size != 2'b00) ram_b[bus_b.mem_a + 8'd1] <= bus_b.mem_di[15:8];
        if (bus_b.mem_size == 2'b10) begin
          ram_b[bus_b.mem_a + 8'd2] <= bus_b.mem_di[23:16];
          ram_b[bus_b.mem_a + 8'd3] <= bus_b.mem_di[31:24];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.req0 = 1'b0; bus_a.rw0 = 1'b0; bus_a.size0 = 2'b00; bus_a.addr0 = 8'h00; bus_a.wdata0 = 32'h0;
    bus_a.req1 = 1'b0; bus_a.rw1 = 1'b0; bus_a.size1 = 2'b00; bus_a.addr1 = 8'h00; bus_a.wdata1 = 32'h0;
    bus_b.req0 = 1'b0; bus_b.rw0 = 1'b0; bus_b.size0 = 2'b00; bus_b.addr0 = 8'h00; bus_b.wdata0 = 32'h0;
    bus_b.req1 = 1'b0; bus_b.rw1 = 1'b0; bus_b.size1 = 2'b00; bus_b.addr1 = 8'h00; bus_b.wdata1 = 32'h0;
  endtask

  task automatic test_reset();
    // reset is high here; request held across reset must be served afresh after release
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b0; bus_a.size0 = 2'b00; bus_a.addr0 = 8'h03;
    step();
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_a: got %0h expected 0", busy_a); end
    tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_b: got %0h expected 0", busy_b); end
    tests_run++; if ({bus_a.ack0, bus_a.ack1, bus_a.err0, bus_a.err1, bus_a.mem_e, bus_a.mem_rw} !== 6'b0) begin tests_failed++; $display("FAIL rst_ctrl: got %b expected 000000", {bus_a.ack0, bus_a.ack1, bus_a.err0, bus_a.err1, bus_a.mem_e, bus_a.mem_rw}); end
    tests_run++; if ({bus_a.rdata0, bus_a.rdata1, bus_a.mem_di, bus_a.mem_a} !== 104'h0) begin tests_failed++; $display("FAIL rst_data: got %h expected 0", {bus_a.rdata0, bus_a.rdata1, bus_a.mem_di, bus_a.mem_a}); end
    reset = 1'b0;
    step();
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL rst_rearb_busy: got %0h expected 1", busy_a); end
    tests_run++; if (bus_a.mem_a !== 8'h03) begin tests_failed++; $display("FAIL rst_rearb_addr: got %h expected 03", bus_a.mem_a); end
    step();
    tests_run++; if (bus_a.ack0 !== 1'b1) begin tests_failed++; $display("FAIL rst_rearb_ack: got %0h expected 1", bus_a.ack0); end
    tests_run++; if (bus_a.rdata0 !== 32'h0000_0059) begin tests_failed++; $display("FAIL rst_rearb_rdata: got %h expected 00000059", bus_a.rdata0); end
    bus_a.req0 = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b1; bus_a.size0 = 2'b10; bus_a.addr0 = 8'h10; bus_a.wdata0 = 32'hDEAD_BEEF;
    tests_run++; if (bus_a.mem_e !== 1'b0) begin tests_failed++; $display("FAIL wr_mem_e_idle: got %0h expected 0", bus_a.mem_e); end
    step();
    tests_run++; if ({bus_a.mem_e, bus_a.mem_rw, bus_a.mem_size} !== 4'b1110) begin tests_failed++; $display("FAIL wr_access_ctrl: got %b expected 1110", {bus_a.mem_e, bus_a.mem_rw, bus_a.mem_size}); end
    tests_run++; if ({bus_a.mem_a, bus_a.mem_di} !== 40'h10_DEADBEEF) begin tests_failed++; $display("FAIL wr_access_bus: got %h expected 10deadbeef", {bus_a.mem_a, bus_a.mem_di}); end
    tests_run++; if (bus_a.ack0 !== 1'b0) begin tests_failed++; $display("FAIL wr_ack_early: got %0h expected 0", bus_a.ack0); end
    step();
    tests_run++; if ({bus_a.ack0, bus_a.err0, bus_a.mem_e} !== 3'b100) begin tests_failed++; $display("FAIL wr_resp: got %b expected 100", {bus_a.ack0, bus_a.err0, bus_a.mem_e}); end
    bus_a.req0 = 1'b0;
    step();
    tests_run++; if ({bus_a.ack0, busy_a} !== 2'b00) begin tests_failed++; $display("FAIL wr_idle: got %b expected 00", {bus_a.ack0, busy_a}); end
    tests_run++; if ({ram_a[8'h13], ram_a[8'h12], ram_a[8'h11], ram_a[8'h10], ram_a[8'h14]} !== 40'hDEADBEEF_4E) begin tests_failed++; $display("FAIL wr_mem: got %h expected deadbeef4e", {ram_a[8'h13], ram_a[8'h12], ram_a[8'h11], ram_a[8'h10], ram_a[8'h14]}); end
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b0; bus_a.wdata0 = 32'h0;
    step();
    tests_run++; if ({bus_a.mem_e, bus_a.mem_rw, bus_a.mem_a} !== 10'b00_0001_0000) begin tests_failed++; $display("FAIL rd_access: got %b expected 0000010000", {bus_a.mem_e, bus_a.mem_rw, bus_a.mem_a}); end
    bus_a.req0 = 1'b0; // dropped before ack: transaction must still complete
    step();
    tests_run++; if ({bus_a.ack0, bus_a.err0} !== 2'b10) begin tests_failed++; $display("FAIL rd_ack: got %b expected 10", {bus_a.ack0, bus_a.err0}); end
    tests_run++; if (bus_a.rdata0 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_rdata: got %h expected deadbeef", bus_a.rdata0); end
    step();
    tests_run++; if ({bus_a.ack0, bus_a.rdata0} !== 33'h0) begin tests_failed++; $display("FAIL rd_after: got %h expected 0", {bus_a.ack0, bus_a.rdata0}); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_rd;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b0; bus_a.size0 = 2'b00; bus_a.addr0 = 8'h01;
    bus_a.req1 = 1'b1; bus_a.rw1 = 1'b0; bus_a.size1 = 2'b00; bus_a.addr1 = 8'h02;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++; if (bus_a.mem_a !== ((k % 2 == 0) ? 8'h01 : 8'h02)) begin tests_failed++; $display("FAIL cont_addr%0d: got %h expected %h", k, bus_a.mem_a, (k % 2 == 0) ? 8'h01 : 8'h02); end
      step();
      exp_rd = (k % 2 == 0) ? 32'h5B : 32'h58;
      if (k % 2 == 0) begin
        tests_run++; if ({bus_a.ack0, bus_a.ack1, bus_a.rdata1} !== 34'h2_0000_0000) begin tests_failed++; $display("FAIL cont_ack%0d: got ack0=%0h ack1=%0h rdata1=%h expected 1 0 0", k, bus_a.ack0, bus_a.ack1, bus_a.rdata1); end
        tests_run++; if (bus_a.rdata0 !== exp_rd) begin tests_failed++; $display("FAIL cont_rdata%0d: got %h expected %h", k, bus_a.rdata0, exp_rd); end
      end else begin
        tests_run++; if ({bus_a.ack0, bus_a.ack1, bus_a.rdata0} !== 34'h1_0000_0000) begin tests_failed++; $display("FAIL cont_ack%0d: got ack0=%0h ack1=%0h rdata0=%h expected 0 1 0", k, bus_a.ack0, bus_a.ack1, bus_a.rdata0); end
        tests_run++; if (bus_a.rdata1 !== exp_rd) begin tests_failed++; $display("FAIL cont_rdata%0d: got %h expected %h", k, bus_a.rdata1, exp_rd); end
      end
      if (k == 3) begin
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
      end
      step();
      tests_run++; if ({bus_a.ack0, bus_a.ack1, busy_a} !== 3'b000) begin tests_failed++; $display("FAIL cont_idle%0d: got %b expected 000", k, {bus_a.ack0, bus_a.ack1, busy_a}); end
    end
  endtask

  task automatic test_illegal();
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b1; bus_a.size0 = 2'b11; bus_a.addr0 = 8'h20; bus_a.wdata0 = 32'h1234_5678;
    step();
    tests_run++; if ({bus_a.ack0, bus_a.err0, bus_a.mem_e} !== 3'b110) begin tests_failed++; $display("FAIL ill_size_resp: got %b expected 110", {bus_a.ack0, bus_a.err0, bus_a.mem_e}); end
    tests_run++; if (bus_a.rdata0 !== 32'h0) begin tests_failed++; $display("FAIL ill_size_rdata: got %h expected 0", bus_a.rdata0); end
    bus_a.req0 = 1'b0;
    step();
    tests_run++; if ({bus_a.ack0, busy_a, ram_a[8'h20]} !== 10'h07A) begin tests_failed++; $display("FAIL ill_size_after: got %h expected 07a", {bus_a.ack0, busy_a, ram_a[8'h20]}); end
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b0; bus_a.size0 = 2'b01; bus_a.addr0 = 8'h21; bus_a.wdata0 = 32'h0;
    step();
    tests_run++; if ({bus_a.ack0, bus_a.err0, bus_a.rdata0} !== 34'h3_0000_0000) begin tests_failed++; $display("FAIL ill_align: got %h expected 300000000", {bus_a.ack0, bus_a.err0, bus_a.rdata0}); end
    bus_a.req0 = 1'b0;
    step();
  endtask

  task automatic test_boundary();
    bus_b.req0 = 1'b1; bus_b.rw0 = 1'b0; bus_b.size0 = 2'b10; bus_b.addr0 = 8'hFD;
    step();
    tests_run++; if ({bus_b.ack0, bus_b.err0, bus_b.rdata0} !== 34'h3_0000_0000) begin tests_failed++; $display("FAIL bnd_word_fd: got %h expected 300000000", {bus_b.ack0, bus_b.err0, bus_b.rdata0}); end
    bus_b.req0 = 1'b0;
    step();
    bus_b.req0 = 1'b1; bus_b.size0 = 2'b00; bus_b.addr0 = 8'hFF;
    step();
    tests_run++; if ({bus_b.ack0, bus_b.mem_a} !== 9'h0FF) begin tests_failed++; $display("FAIL bnd_byte_access: got %h expected 0ff", {bus_b.ack0, bus_b.mem_a}); end
    step();
    tests_run++; if ({bus_b.ack0, bus_b.err0, bus_b.rdata0} !== 34'h2_0000_00A5) begin tests_failed++; $display("FAIL bnd_byte_ff: got %h expected 2000000a5", {bus_b.ack0, bus_b.err0, bus_b.rdata0}); end
    bus_b.req0 = 1'b0;
    step();
    bus_b.req0 = 1'b1; bus_b.size0 = 2'b01; bus_b.addr0 = 8'h21;
    step();
    step();
    tests_run++; if ({bus_b.ack0, bus_b.err0, bus_b.rdata0} !== 34'h2_0000_787B) begin tests_failed++; $display("FAIL bnd_half_21: got %h expected 20000787b", {bus_b.ack0, bus_b.err0, bus_b.rdata0}); end
    bus_b.req0 = 1'b0;
    step();
    bus_b.req0 = 1'b1; bus_b.size0 = 2'b10; bus_b.addr0 = 8'hFC;
    step();
    step();
    tests_run++; if ({bus_b.ack0, bus_b.err0, bus_b.rdata0} !== 34'h2_A5A4_A7A6) begin tests_failed++; $display("FAIL bnd_word_fc: got %h expected 2a5a4a7a6", {bus_b.ack0, bus_b.err0, bus_b.rdata0}); end
    bus_b.req0 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int acks;
    bus_a.req0 = 1'b1; bus_a.rw0 = 1'b1; bus_a.size0 = 2'b00; bus_a.addr0 = 8'h40; bus_a.wdata0 = 32'h0000_005A;
    step();
    tests_run++; if (bus_a.mem_e !== 1'b1) begin tests_failed++; $display("FAIL rmid_mem_e_before: got %0h expected 1", bus_a.mem_e); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if ({bus_a.mem_e, busy_a, bus_a.ack0} !== 3'b000) begin tests_failed++; $display("FAIL rmid_async: got %b expected 000", {bus_a.mem_e, busy_a, bus_a.ack0}); end
    bus_a.req0 = 1'b0;
    step();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_a.ack0 === 1'b1) acks++;
    end
    tests_run++; if (acks !== 0) begin tests_failed++; $display("FAIL rmid_no_ack: got %0d acks expected 0", acks); end
    tests_run++; if (ram_a[8'h40] !== 8'h1A) begin tests_failed++; $display("FAIL rmid_mem: got %h expected 1a", ram_a[8'h40]); end
  endtask

  task automatic test_input_hold();
    bus_a.req1 = 1'b1; bus_a.rw1 = 1'b1; bus_a.size1 = 2'b00; bus_a.addr1 = 8'h08; bus_a.wdata1 = 32'h0000_0077;
    step();
    bus_a.addr1 = 8'h0C; bus_a.wdata1 = 32'h0000_0099; bus_a.size1 = 2'b10;
    #1;
    tests_run++; if ({bus_a.mem_a, bus_a.mem_di, bus_a.mem_size} !== 42'h08_0000_0077 << 2) begin tests_failed++; $display("FAIL hold_bus: got a=%h di=%h size=%b expected 08 00000077 00", bus_a.mem_a, bus_a.mem_di, bus_a.mem_size); end
    step();
    tests_run++; if ({bus_a.ack1, bus_a.err1, bus_a.ack0} !== 3'b100) begin tests_failed++; $display("FAIL hold_ack: got %b expected 100", {bus_a.ack1, bus_a.err1, bus_a.ack0}); end
    bus_a.req1 = 1'b0;
    step();
    tests_run++; if ({ram_a[8'h08], ram_a[8'h0C]} !== 16'h7756) begin tests_failed++; $display("FAIL hold_mem: got %h expected 7756", {ram_a[8'h08], ram_a[8'h0C]}); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    ram_init     = 1'b1;
    idle_inputs();
    step();
    ram_init = 1'b0;
    test_reset();
    test_write_read();
    test_contention();
    test_illegal();
    test_boundary();
    test_reset_mid();
    test_input_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ALIGN_CHECK, default 1: 1 = reject misaligned halfword/word accesses; 0 = permit them, subject to REQ-016.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
REQ-003 Each requester port n (n = 0: CPU MEM stage; n = 1: loader/debug) SHALL have:
- reqn  in  1  request; held high until ackn.
- rwn  in  1  0 = read, 1 = write.
- sizen  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- addrn  in  8  byte address.
- wdatan  in  32  write data, right-aligned.
- ackn  out  1  one-cycle completion pulse.
- errn  out  1  valid with ackn; access rejected.
- rdatan  out  32  valid with ackn on reads.
REQ-004 The memory side SHALL have:
- mem_a  out  8  address.
- mem_di  out  32  write data.
- mem_size  out  2  access size.
- mem_rw  out  1  0 = read, 1 = write.
- mem_e  out  1  write enable.
- mem_do  in  32  combinational read data.
REQ-005 Status SHALL be: busy  out  1  high when the FSM is not in IDLE.

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-007 In IDLE with any reqn high, the block SHALL arbitrate, latch the winner's rw/size/addr/wdata and owner id, and move to ACCESS, or to RESP if the request is illegal.
REQ-008 Arbitration SHALL be round-robin on a last_grant register:
- A single requester wins.
- If both request, the port not equal to last_grant wins.
- last_grant updates on every grant.
REQ-009 In ACCESS, the block SHALL drive the mem_* outputs from the latched request for exactly one cycle.
- Write: mem_rw = 1, mem_e = 1 for that cycle only.
- Read: mem_rw = 0, mem_e = 0, and mem_do is captured into the read-data register at the ACCESS-ending edge.
REQ-010 In RESP, the block SHALL assert ackn of the owner only for one cycle, drive errn, and drive rdatan from the capture register; the FSM then returns to IDLE.
REQ-011 The non-owner's ack/err SHALL stay 0, and its rdata SHALL be 0 whenever its ack is low.
REQ-012 Latency for a legal access SHALL be: request sampled in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2; one transaction per 3 cycles maximum.
REQ-013 Latency for an illegal access SHALL be: sampled at N -> ack with err = 1 at N+1, with no memory cycle (mem_e never asserted).
REQ-014 The following SHALL be illegal: size = 11; with ALIGN_CHECK = 1, a halfword with addr[0] = 1 or a word with addr[1:0] != 00.
REQ-015 On an illegal access, rdatan SHALL be 0 and errn SHALL be 1.
REQ-016 With ALIGN_CHECK = 0, an access SHALL be illegal when addr + bytes - 1 > 255 (e.g. a word at 0xFE); no wrap-around is performed.
REQ-017 Request handling after grant:
- Changes to the granted port's inputs after the grant SHALL be ignored.
- Deasserting req before ack SHALL NOT abort the transaction; the ack is still issued.
- A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-018 Outside ACCESS, mem_a, mem_di and mem_size SHALL be 0, and mem_rw and mem_e SHALL be 0.
REQ-019 Read data SHALL be passed through unmodified; zero-extension is the memory's responsibility, and the block SHALL NOT sign-extend.

Reset
REQ-020 Assertion of reset SHALL immediately force state = IDLE, last_grant = 1 (port 0 wins the first contention), and all outputs to 0, including mem_e, ack0/1, err0/1, rdata0/1 and busy.
REQ-021 Reset during ACCESS SHALL remove mem_e before the next clock edge, so no write occurs; the interrupted request is dropped without ack.
REQ-022 After reset deasserts, a still-high req SHALL be arbitrated afresh.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Word write then read: port 0 writes 0xDEADBEEF to 0x10 (size 10), then reads 0x10 -> mem_e high for exactly one cycle; the read ack at N+2 carries rdata0 = 0xDEADBEEF, err0 = 0.
- Simultaneous contention after reset: req0 and req1 both high -> port 0 is served first and port 1 second; with both held high, grants alternate 0, 1, 0, 1, one ack every 3 cycles.
- Illegal requests: size 11 at 0x20 -> ack at N+1 with err = 1, rdata = 0, no mem_e; a halfword at 0x21 with ALIGN_CHECK = 1 -> err = 1.
- Boundary: ALIGN_CHECK = 0, word at 0xFD -> err = 1; byte at 0xFF -> legal, rdata = {24'b0, Mem[0xFF]}.
- Reset mid-transaction: reset asserted during ACCESS of a byte write of 0x5A to 0x40 -> mem_e drops asynchronously, Mem[0x40] is unchanged, no ack, busy = 0.
- Input hold: the port 1 address changes from 0x08 to 0x0C during ACCESS -> the memory access uses 0x08.
